// File: rtl/axi_interconnect_pkg.sv
// Shared definitions for the AXI interconnect default-slave responder:
// response codes, responder FSM states and a constant log2 helper.
package axi_interconnect_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WDRAIN = 2'd1,
    ST_WRESP  = 2'd2,
    ST_RDATA  = 2'd3
  } state_t;

  // Ceiling log2 for elaboration-time sizing; LOG2(1) = 0.
  function automatic int LOG2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_interconnect_sync_fifo.sv
// Synchronous FIFO holding pending requests for the default slave.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axi_interconnect_sync_fifo
  import axi_interconnect_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = LOG2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Advance read/write pointers; reset empties the queue.
  always_ff @(posedge clk_sys) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Store pushed entries.
  always_ff @(posedge clk_sys) begin
    // NOTE: storage is not reset; the pointers alone define which entries
    // are valid, so clearing the array would only cost reset fan-out.
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/axi_interconnect_default_slave.sv
// Default slave for one crossbar master port whose address maps nowhere.
// Queues requests, drains write data up to WLAST, and answers every burst
// with DECERR: one B per write burst or LEN+1 R beats per read burst.
module axi_interconnect_default_slave
  import axi_interconnect_pkg::*;
#(
  parameter int MODE_READ       = 1,
  parameter int WIDTH_ID        = 4,
  parameter int WIDTH_DATA      = 32,
  parameter int WIDTH_RUSER     = 1,
  parameter int WIDTH_ADDRINFO  = 64,
  parameter int WIDTH_DATAINFO  = 48,
  parameter int WIDTH_RESPINFO  = 48,
  parameter int ID_LSB          = 0,
  parameter int LEN_LSB         = 32,
  parameter int NUM_OUTSTANDING = 4
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic [WIDTH_ADDRINFO-1:0] addr_info,
  input  logic                      addr_valid,
  output logic                      addr_ready,
  input  logic [WIDTH_DATAINFO-1:0] wdata_info,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  output logic [WIDTH_RESPINFO-1:0] resp_info,
  output logic                      resp_valid,
  input  logic                      resp_ready
);

  localparam int REQ_W     = WIDTH_ID + 8;
  localparam int RD_RESP_W = WIDTH_ID + WIDTH_DATA + WIDTH_RUSER + 3;
  localparam int WR_RESP_W = WIDTH_ID + 2;

  logic [REQ_W-1:0]          w_req_in;
  logic [REQ_W-1:0]          w_req_head;
  logic [WIDTH_ID-1:0]       w_head_id;
  logic [7:0]                w_head_len;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic                      w_fifo_pop;
  logic                      w_unused;

  state_t                    r_state;
  logic [7:0]                r_beat_cnt;
  logic [WIDTH_ID-1:0]       r_id;
  logic                      r_wdata_ready;
  logic                      r_resp_valid;
  logic [WIDTH_RESPINFO-1:0] r_resp_info;

  // R payload {ID, DATA=0, RUSER=0, RESP, LAST}, LSB-aligned and zero-padded.
  function automatic logic [WIDTH_RESPINFO-1:0] read_beat(
    input logic [WIDTH_ID-1:0] id,
    input logic                last
  );
    logic [RD_RESP_W-1:0] beat;
    beat = {id, {WIDTH_DATA{1'b0}}, {WIDTH_RUSER{1'b0}}, RESP_DECERR, last};
    return WIDTH_RESPINFO'(beat);
  endfunction

  // B payload {ID, RESP}, LSB-aligned and zero-padded.
  function automatic logic [WIDTH_RESPINFO-1:0] write_resp(
    input logic [WIDTH_ID-1:0] id
  );
    logic [WR_RESP_W-1:0] resp;
    resp = {id, RESP_DECERR};
    return WIDTH_RESPINFO'(resp);
  endfunction

  assign w_req_in   = {addr_info[ID_LSB +: WIDTH_ID], addr_info[LEN_LSB +: 8]};
  assign w_head_id  = w_req_head[REQ_W-1:8];
  assign w_head_len = w_req_head[7:0];
  assign w_fifo_pop = (r_state == ST_IDLE) && !w_fifo_empty;

  // Request is taken the same cycle it is offered unless the queue is full.
  assign addr_ready  = ~w_fifo_full & ~rst;
  assign wdata_ready = r_wdata_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_info   = r_resp_info;

  // Payload bits other than ID, LEN and WLAST carry nothing for a DECERR.
  assign w_unused = ^{addr_info, wdata_info, wdata_valid};

  axi_interconnect_sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (NUM_OUTSTANDING)
  ) u_req_fifo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .i_data  (w_req_in),
    .i_push  (addr_valid & addr_ready),
    .i_pop   (w_fifo_pop),
    .o_data  (w_req_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Responder FSM: serve queued requests in order with registered outputs.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_beat_cnt    <= 8'd0;
      r_id          <= '0;
      r_wdata_ready <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_info   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_id <= w_head_id;
            if (MODE_READ != 0) begin
              r_state      <= ST_RDATA;
              r_beat_cnt   <= w_head_len;
              r_resp_valid <= 1'b1;
              r_resp_info  <= read_beat(w_head_id, w_head_len == 8'd0);
            end else begin
              r_state       <= ST_WDRAIN;
              r_wdata_ready <= 1'b1;
            end
          end
        end
        ST_WDRAIN: begin
          // Beats are discarded; WLAST alone ends the burst.
          if (wdata_valid && r_wdata_ready && wdata_info[0]) begin
            r_state       <= ST_WRESP;
            r_wdata_ready <= 1'b0;
            r_resp_valid  <= 1'b1;
            r_resp_info   <= write_resp(r_id);
          end
        end
        ST_WRESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        ST_RDATA: begin
          if (resp_ready) begin
            if (r_beat_cnt == 8'd0) begin
              r_state      <= ST_IDLE;
              r_resp_valid <= 1'b0;
            end else begin
              r_beat_cnt  <= r_beat_cnt - 8'd1;
              r_resp_info <= read_beat(r_id, r_beat_cnt == 8'd1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
